usb_reg_arbiter: RTL and testbench

- Shares the register bus between the USB front-end (host-driven) and one internal master, for example an autonomous config/readback sequencer.
- USB always has absolute priority because the host cannot be stalled.
- The internal master gets the bus only after a guard period of USB idleness, and is aborted as soon as USB activity appears.
- Sits between the USB register front-end and all register-decoding blocks.

---
 rtl/usb_reg_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_usb_reg_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_reg_arbiter.sv
// usb_reg_arbiter
// Arbitrates the shared register bus between the host-driven USB front-end
// and one internal master (e.g. a config/readback sequencer). USB always
// wins: the internal master is granted only after a run of USB-idle cycles,
// and it loses the bus in the same cycle USB activity appears.
module usb_reg_arbiter #(
  parameter int pBYTECNT_SIZE = 7,
  parameter int pIDLE_CYCLES  = 16,
  parameter int pMAX_GRANT    = 4096
) (
  input  logic                     clk_usb,
  input  logic                     reset_n,

  input  logic                     usb_active,
  input  logic [7:0]               usb_address,
  input  logic [pBYTECNT_SIZE-1:0] usb_bytecnt,
  input  logic [7:0]               usb_datao,
  input  logic                     usb_write,
  input  logic                     usb_read,

  input  logic                     int_req,
  output logic                     int_gnt,
  output logic                     int_abort,
  input  logic                     int_done,
  input  logic [7:0]               int_address,
  input  logic [7:0]               int_datao,
  input  logic                     int_write,
  input  logic                     int_read,

  input  logic [7:0]               reg_datai,
  output logic [7:0]               int_datai,
  output logic [7:0]               reg_address,
  output logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
  output logic [7:0]               reg_datao,
  output logic                     reg_write,
  output logic                     reg_read,
  output logic                     owner_int
);

  // Grant watchdog counter just wide enough to hold pMAX_GRANT-1.
  localparam int GCNT_W = (pMAX_GRANT > 2) ? $clog2(pMAX_GRANT) : 1;
  localparam logic [GCNT_W-1:0] GCNT_LAST   = GCNT_W'(pMAX_GRANT - 1);
  localparam logic [7:0]        IDLE_TARGET = 8'(pIDLE_CYCLES);

  typedef enum logic [1:0] {
    S_USB     = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t                   state_reg,     state_next;
  logic [7:0]               idle_cnt_reg,  idle_cnt_next;
  logic [GCNT_W-1:0]        grant_cnt_reg, grant_cnt_next;
  logic [pBYTECNT_SIZE-1:0] byte_cnt_reg,  byte_cnt_next;
  logic                     int_gnt_reg,   int_gnt_next;
  logic                     int_abort_reg, int_abort_next;

  // 1-cycle history used by the internal byte counter.
  logic [7:0]               int_address_reg;
  logic                     int_read_own_reg;

  // Decoded FSM events shared by the counters.
  logic                     grant_entry;
  logic                     leave_grant;

  // Byte counter event decode.
  logic                     addr_changed;
  logic                     read_fall;
  logic                     byte_step;

  // Ownership is combinational so USB reclaims the bus with zero latency.
  assign owner_int = (state_reg == S_GRANT) && !usb_active;
  assign int_gnt   = int_gnt_reg;
  assign int_abort = int_abort_reg;
  assign int_datai = reg_datai;

  // State register and all arbiter counters.
  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= S_USB;
      idle_cnt_reg  <= '0;
      grant_cnt_reg <= '0;
      byte_cnt_reg  <= '0;
      int_gnt_reg   <= 1'b0;
      int_abort_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idle_cnt_reg  <= idle_cnt_next;
      grant_cnt_reg <= grant_cnt_next;
      byte_cnt_reg  <= byte_cnt_next;
      int_gnt_reg   <= int_gnt_next;
      int_abort_reg <= int_abort_next;
    end
  end

  // Registered copies of the internal address and owned read level.
  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      int_address_reg  <= '0;
      int_read_own_reg <= 1'b0;
    end else begin
      int_address_reg  <= int_address;
      int_read_own_reg <= int_read && owner_int;
    end
  end

  // Next-state logic: USB first, watchdog second, voluntary release last.
  always_comb begin
    state_next     = state_reg;
    grant_cnt_next = grant_cnt_reg;
    int_abort_next = 1'b0;
    grant_entry    = 1'b0;
    leave_grant    = 1'b0;

    case (state_reg)
      S_USB: begin
        if (int_req && (idle_cnt_reg == IDLE_TARGET) && !usb_active) begin
          state_next     = S_GRANT;
          grant_cnt_next = '0;
          grant_entry    = 1'b1;
        end
      end

      S_GRANT: begin
        if (usb_active || (grant_cnt_reg == GCNT_LAST)) begin
          // Revoked without the master's consent: tell it with a pulse.
          state_next     = S_USB;
          int_abort_next = 1'b1;
          leave_grant    = 1'b1;
        end else if (int_done || !int_req) begin
          state_next     = S_RELEASE;
          leave_grant    = 1'b1;
        end else begin
          grant_cnt_next = grant_cnt_reg + GCNT_W'(1);
        end
      end

      S_RELEASE: begin
        state_next = S_USB;
      end

      default: begin
        state_next = S_USB;
      end
    endcase

    int_gnt_next = (state_next == S_GRANT);
  end

  // Idle counter: saturating run length of USB-idle cycles, restarted
  // whenever the internal master loses or gives up the bus.
  always_comb begin
    idle_cnt_next = idle_cnt_reg;
    if (usb_active || leave_grant) begin
      idle_cnt_next = '0;
    end else if (idle_cnt_reg < IDLE_TARGET) begin
      idle_cnt_next = idle_cnt_reg + 8'd1;
    end
  end

  // Internal byte counter: restarts per grant and per address, steps after
  // each owned write strobe and at the end of each owned read.
  always_comb begin
    addr_changed  = (int_address != int_address_reg);
    read_fall     = int_read_own_reg && !int_read;
    byte_step     = (int_write && owner_int) || read_fall;
    byte_cnt_next = byte_cnt_reg;
    if (grant_entry || addr_changed) begin
      byte_cnt_next = '0;
    end else if (byte_step) begin
      byte_cnt_next = byte_cnt_reg + pBYTECNT_SIZE'(1);
    end
  end

  // Register-bus mux; strobes are blanked during the dead cycle unless USB
  // has already come back.
  always_comb begin
    reg_address = usb_address;
    reg_bytecnt = usb_bytecnt;
    reg_datao   = usb_datao;
    reg_write   = usb_write;
    reg_read    = usb_read;
    if (owner_int) begin
      reg_address = int_address;
      reg_bytecnt = byte_cnt_reg;
      reg_datao   = int_datao;
      reg_write   = int_write;
      reg_read    = int_read;
    end else if ((state_reg == S_RELEASE) && !usb_active) begin
      reg_write   = 1'b0;
      reg_read    = 1'b0;
    end
  end

endmodule

// File: tb/tb_usb_reg_arbiter.sv
// Self-checking bench for usb_reg_arbiter. Expected register-bus values are
// queued when stimulus is driven and compared when the cycle is sampled.
// u_dut uses a 64-cycle watchdog; u_dut_long keeps the default watchdog so
// that a 130-write burst fits in one grant.
module tb_usb_reg_arbiter;

  logic       clk_usb = 1'b0;
  logic       reset_n;
  logic       usb_active;
  logic [7:0] usb_address;
  logic [6:0] usb_bytecnt;
  logic [7:0] usb_datao;
  logic       usb_write;
  logic       usb_read;
  logic       int_req;
  logic       int_done;
  logic [7:0] int_address;
  logic [7:0] int_datao;
  logic       int_write;
  logic       int_read;
  logic [7:0] reg_datai;

  logic       gnt_a, abort_a, own_a, wr_a, rd_a;
  logic [7:0] datai_a, addr_a, do_a;
  logic [6:0] bc_a;
  logic       gnt_b, abort_b, own_b, wr_b, rd_b;
  logic [7:0] datai_b, addr_b, do_b;
  logic [6:0] bc_b;

  logic [24:0] bus_a, bus_b;
  assign bus_a = {addr_a, bc_a, do_a, wr_a, rd_a};
  assign bus_b = {addr_b, bc_b, do_b, wr_b, rd_b};

  int checks   = 0;
  int failures = 0;

  logic [24:0] exp_q[$];
  string       tag_q[$];

  always #5 clk_usb = ~clk_usb;

  usb_reg_arbiter #(.pBYTECNT_SIZE(7), .pIDLE_CYCLES(16), .pMAX_GRANT(64)) u_dut (
    .clk_usb(clk_usb), .reset_n(reset_n),
    .usb_active(usb_active), .usb_address(usb_address), .usb_bytecnt(usb_bytecnt),
    .usb_datao(usb_datao), .usb_write(usb_write), .usb_read(usb_read),
    .int_req(int_req), .int_gnt(gnt_a), .int_abort(abort_a), .int_done(int_done),
    .int_address(int_address), .int_datao(int_datao), .int_write(int_write),
    .int_read(int_read), .reg_datai(reg_datai), .int_datai(datai_a),
    .reg_address(addr_a), .reg_bytecnt(bc_a), .reg_datao(do_a),
    .reg_write(wr_a), .reg_read(rd_a), .owner_int(own_a)
  );

  usb_reg_arbiter #(.pBYTECNT_SIZE(7), .pIDLE_CYCLES(16), .pMAX_GRANT(4096)) u_dut_long (
    .clk_usb(clk_usb), .reset_n(reset_n),
    .usb_active(usb_active), .usb_address(usb_address), .usb_bytecnt(usb_bytecnt),
    .usb_datao(usb_datao), .usb_write(usb_write), .usb_read(usb_read),
    .int_req(int_req), .int_gnt(gnt_b), .int_abort(abort_b), .int_done(int_done),
    .int_address(int_address), .int_datao(int_datao), .int_write(int_write),
    .int_read(int_read), .reg_datai(reg_datai), .int_datai(datai_b),
    .reg_address(addr_b), .reg_bytecnt(bc_b), .reg_datao(do_b),
    .reg_write(wr_b), .reg_read(rd_b), .owner_int(own_b)
  );

  // Advance to just after the next active edge (drive point).
  task automatic tick();
    @(posedge clk_usb);
    #1;
  endtask

  // Move to the sample point in the middle of the current cycle.
  task automatic samp();
    @(negedge clk_usb);
  endtask

  task automatic push_exp(input string tag, input logic [7:0] a, input logic [6:0] bc,
                          input logic [7:0] d, input logic w, input logic r);
    exp_q.push_back({a, bc, d, w, r});
    tag_q.push_back(tag);
  endtask

  task automatic check_bus(input logic [24:0] obs);
    logic [24:0] e;
    string       t;
    checks++;
    assert (exp_q.size() != 0) else begin
      failures++;
      $error("FAIL sb_empty observed=%h expected=queued_entry", obs);
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s observed addr=%h bc=%0d do=%h wr=%b rd=%b expected addr=%h bc=%0d do=%h wr=%b rd=%b",
             t, obs[24:17], obs[16:10], obs[9:2], obs[1], obs[0],
             e[24:17], e[16:10], e[9:2], e[1], e[0]);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Bounded wait for u_dut's grant; leaves the bench in the first granted cycle.
  task automatic wait_gnt(input string tag, input int budget);
    int n;
    n = 0;
    while (gnt_a !== 1'b1 && n < budget) begin
      tick();
      samp();
      n++;
    end
    chk(tag, {31'd0, gnt_a}, 32'd1);
  endtask

  initial begin
    logic [7:0] d;

    // ---------------- reset state ----------------
    reset_n     = 1'b0;
    usb_active  = 1'b0;
    usb_address = 8'h33;
    usb_bytecnt = 7'd5;
    usb_datao   = 8'hA5;
    usb_write   = 1'b1;
    usb_read    = 1'b0;
    int_req     = 1'b0;
    int_done    = 1'b0;
    int_address = 8'h20;
    int_datao   = 8'h00;
    int_write   = 1'b0;
    int_read    = 1'b0;
    reg_datai   = 8'h00;
    repeat (3) @(posedge clk_usb);
    samp();
    push_exp("rst_bus_passthrough", 8'h33, 7'd5, 8'hA5, 1'b1, 1'b0);
    check_bus(bus_a);
    chk("rst_int_gnt",   {31'd0, gnt_a},   32'd0);
    chk("rst_int_abort", {31'd0, abort_a}, 32'd0);
    chk("rst_owner_int", {31'd0, own_a},   32'd0);
    tick();
    reset_n = 1'b1;

    // ---------------- 1: USB-only random traffic ----------------
    for (int i = 0; i < 100; i++) begin
      tick();
      usb_active  = 1'($urandom);
      usb_address = 8'($urandom);
      usb_bytecnt = 7'($urandom);
      usb_datao   = 8'($urandom);
      usb_write   = 1'($urandom);
      usb_read    = 1'($urandom);
      reg_datai   = 8'($urandom);
      push_exp("t1_usb_passthrough", usb_address, usb_bytecnt, usb_datao, usb_write, usb_read);
      samp();
      check_bus(bus_a);
      chk("t1_int_gnt_low", {31'd0, gnt_a}, 32'd0);
      if (i % 10 == 0) chk("t1_int_datai", {24'd0, datai_a}, {24'd0, reg_datai});
    end

    // ---------------- 2: grant after 16 idle cycles, 3 writes, done ----------------
    tick();
    usb_active  = 1'b1;
    usb_write   = 1'b0;
    usb_read    = 1'b0;
    usb_address = 8'h77;
    usb_bytecnt = 7'd1;
    usb_datao   = 8'hEE;
    int_req     = 1'b1;
    int_address = 8'h20;
    tick();
    usb_active  = 1'b0;                 // cycle 0: first idle cycle
    for (int k = 1; k <= 16; k++) begin
      tick();
      samp();
      chk("t2_no_gnt_before_edge17", {31'd0, gnt_a}, 32'd0);
    end
    tick();
    samp();
    chk("t2_gnt_on_edge17", {31'd0, gnt_a}, 32'd1);
    chk("t2_owner_int",     {31'd0, own_a}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      int_write = 1'b1;
      int_datao = 8'h5A;
      reg_datai = 8'hC3;
      push_exp("t2_int_write", 8'h20, 7'(i), 8'h5A, 1'b1, 1'b0);
      samp();
      check_bus(bus_a);
    end
    chk("t2_int_datai", {24'd0, datai_a}, 32'h0000_00C3);
    tick();
    int_write = 1'b0;
    int_done  = 1'b1;
    int_req   = 1'b0;
    push_exp("t2_done_cycle", 8'h20, 7'd3, 8'h5A, 1'b0, 1'b0);
    samp();
    check_bus(bus_a);
    chk("t2_gnt_in_done_cycle", {31'd0, gnt_a}, 32'd1);
    tick();
    int_done    = 1'b0;
    usb_write   = 1'b1;
    usb_read    = 1'b1;
    usb_address = 8'h44;
    usb_bytecnt = 7'd9;
    usb_datao   = 8'h3C;
    push_exp("t2_release_strobes_blanked", 8'h44, 7'd9, 8'h3C, 1'b0, 1'b0);
    samp();
    check_bus(bus_a);
    chk("t2_release_gnt",   {31'd0, gnt_a},   32'd0);
    chk("t2_release_owner", {31'd0, own_a},   32'd0);
    chk("t2_release_abort", {31'd0, abort_a}, 32'd0);
    tick();
    push_exp("t2_usb_restored", 8'h44, 7'd9, 8'h3C, 1'b1, 1'b1);
    samp();
    check_bus(bus_a);
    tick();
    usb_write = 1'b0;
    usb_read  = 1'b0;

    // ---------------- 3: USB preempts a grant ----------------
    int_req = 1'b1;
    samp();
    wait_gnt("t3_initial_grant", 40);
    tick();
    int_write   = 1'b1;
    int_datao   = 8'h66;
    usb_active  = 1'b1;
    usb_address = 8'h55;
    usb_bytecnt = 7'd3;
    usb_datao   = 8'h99;
    push_exp("t3_usb_wins_bus", 8'h55, 7'd3, 8'h99, 1'b0, 1'b0);
    samp();
    check_bus(bus_a);
    chk("t3_owner_dropped",  {31'd0, own_a},   32'd0);
    chk("t3_abort_not_yet",  {31'd0, abort_a}, 32'd0);
    tick();
    int_write = 1'b0;
    samp();
    chk("t3_abort_pulse",    {31'd0, abort_a}, 32'd1);
    chk("t3_gnt_dropped",    {31'd0, gnt_a},   32'd0);
    tick();
    samp();
    chk("t3_abort_one_cycle", {31'd0, abort_a}, 32'd0);
    tick();
    usb_active = 1'b0;                  // cycle 0 of fresh idle run
    for (int k = 1; k <= 16; k++) begin
      tick();
      samp();
      chk("t3_no_early_regrant", {31'd0, gnt_a}, 32'd0);
    end
    tick();
    samp();
    chk("t3_regrant_edge17", {31'd0, gnt_a}, 32'd1);

    // ---------------- 4: watchdog abort after 64 cycles ----------------
    for (int k = 1; k <= 63; k++) begin
      tick();
      samp();
      chk("t4_no_abort_yet", {30'd0, abort_a, gnt_a}, 32'd1);
    end
    tick();
    samp();
    chk("t4_watchdog_abort", {31'd0, abort_a}, 32'd1);
    chk("t4_gnt_dropped",    {31'd0, gnt_a},   32'd0);
    chk("t4_owner_usb",      {31'd0, own_a},   32'd0);
    tick();
    samp();
    chk("t4_abort_one_cycle", {31'd0, abort_a}, 32'd0);

    // ---------------- 6: reset mid-grant ----------------
    wait_gnt("t6_grant_before_reset", 40);
    tick();
    reset_n = 1'b0;
    #1;
    chk("t6_gnt_async_drop", {31'd0, gnt_a},   32'd0);
    chk("t6_owner_async",    {31'd0, own_a},   32'd0);
    chk("t6_no_abort",       {31'd0, abort_a}, 32'd0);
    tick();
    reset_n = 1'b1;                     // cycle 0 after reset
    for (int k = 1; k <= 16; k++) begin
      tick();
      samp();
      chk("t6_fresh_idle_needed", {31'd0, gnt_a}, 32'd0);
    end
    tick();
    samp();
    chk("t6_grant_edge17",      {31'd0, gnt_a}, 32'd1);
    chk("t5_long_grant_edge17", {31'd0, gnt_b}, 32'd1);

    // ---------------- 5: byte count address clear and wrap ----------------
    for (int i = 0; i < 2; i++) begin
      tick();
      int_write = 1'b1;
      int_datao = 8'h11 + 8'(i);
      push_exp("t5_write_0x20", 8'h20, 7'(i), int_datao, 1'b1, 1'b0);
      samp();
      check_bus(bus_b);
    end
    tick();
    int_write   = 1'b0;
    int_address = 8'h21;
    push_exp("t5_addr_change_cycle", 8'h21, 7'd2, 8'h12, 1'b0, 1'b0);
    samp();
    check_bus(bus_b);
    tick();
    push_exp("t5_bytecnt_cleared", 8'h21, 7'd0, 8'h12, 1'b0, 1'b0);
    samp();
    check_bus(bus_b);
    for (int i = 0; i < 130; i++) begin
      tick();
      d         = 8'(i);
      int_write = 1'b1;
      int_datao = d;
      push_exp("t5_wrap_write", 8'h21, 7'(i % 128), d, 1'b1, 1'b0);
      samp();
      check_bus(bus_b);
    end
    tick();
    int_write = 1'b0;
    int_read  = 1'b1;
    push_exp("t5_read_level_1", 8'h21, 7'd2, 8'h81, 1'b0, 1'b1);
    samp();
    check_bus(bus_b);
    tick();
    push_exp("t5_read_level_2", 8'h21, 7'd2, 8'h81, 1'b0, 1'b1);
    samp();
    check_bus(bus_b);
    tick();
    int_read = 1'b0;
    push_exp("t5_read_fall", 8'h21, 7'd2, 8'h81, 1'b0, 1'b0);
    samp();
    check_bus(bus_b);
    tick();
    push_exp("t5_read_counted", 8'h21, 7'd3, 8'h81, 1'b0, 1'b0);
    samp();
    check_bus(bus_b);
    chk("t5_long_no_abort", {31'd0, abort_b}, 32'd0);
    tick();
    int_done = 1'b1;
    int_req  = 1'b0;
    tick();
    int_done = 1'b0;
    samp();
    chk("t5_long_released", {31'd0, gnt_b}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
